// File: rtl/mips_writeback_stage.sv
// MIPS write-back stage: MEM/WB pipeline register, load-data extraction,
// register file write port with $0 suppression, read bypass and retire counter.
module mips_writeback_stage #(
    parameter int Width = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic             mem_mem_to_reg,
    input  logic [2:0]       mem_load_type,
    input  logic [1:0]       mem_byte_off,
    input  logic [Width-1:0] mem_alu_result,
    input  logic [Width-1:0] mem_read_data,
    input  logic [4:0]       mem_dest,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       rd_a1,
    input  logic [4:0]       rd_a2,
    input  logic [Width-1:0] rf_rd1,
    input  logic [Width-1:0] rf_rd2,
    output logic             WE3,
    output logic [4:0]       A3,
    output logic [Width-1:0] WD3,
    output logic [Width-1:0] rd1_fwd,
    output logic [Width-1:0] rd2_fwd,
    output logic             wb_valid,
    output logic [CNT_W-1:0] retired_count
);

    localparam logic [2:0] LT_LB  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b010;
    localparam logic [2:0] LT_LH  = 3'b011;
    localparam logic [2:0] LT_LHU = 3'b100;

    // Little-endian byte/halfword pick; unknown load types fall back to lw.
    function automatic logic [Width-1:0] load_extract(
        input logic [2:0]       lt,
        input logic [1:0]       off,
        input logic [Width-1:0] word
    );
        logic [7:0]              b;
        logic [15:0]             h;
        logic signed [Width-1:0] sb;
        logic signed [Width-1:0] sh;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h  = off[1] ? word[31:16] : word[15:0];
        sb = $signed(b);
        sh = $signed(h);
        case (lt)
            LT_LB:   return sb;
            LT_LBU:  return {{(Width-8){1'b0}}, b};
            LT_LH:   return sh;
            LT_LHU:  return {{(Width-16){1'b0}}, h};
            default: return word;
        endcase
    endfunction

    logic             vld_p1;
    logic             reg_write_p1;
    logic [4:0]       dest_p1;
    logic [Width-1:0] data_p1;
    logic [Width-1:0] result_p0;

    assign result_p0 = mem_mem_to_reg
                     ? load_extract(mem_load_type, mem_byte_off, mem_read_data)
                     : mem_alu_result;

    // MEM -> WB boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1        <= 1'b0;
            reg_write_p1  <= 1'b0;
            dest_p1       <= 5'd0;
            data_p1       <= '0;
            retired_count <= '0;
        end else begin
            if (flush) begin
                vld_p1 <= 1'b0;
            end else if (!stall) begin
                vld_p1       <= mem_valid;
                reg_write_p1 <= mem_reg_write;
                dest_p1      <= mem_dest;
                data_p1      <= result_p0;
            end
            if (vld_p1 && !stall && !flush)
                retired_count <= retired_count + CNT_W'(1);
        end
    end

    // WB -> register file write port
    assign wb_valid = vld_p1;
    assign A3       = dest_p1;
    assign WD3      = data_p1;
    assign WE3      = vld_p1 & reg_write_p1 & (dest_p1 != 5'd0);

    always_comb begin
        rd1_fwd = rf_rd1;
        rd2_fwd = rf_rd2;
        if (rd_a1 == 5'd0)
            rd1_fwd = '0;
        else if (WE3 && (rd_a1 == A3))
            rd1_fwd = WD3;
        if (rd_a2 == 5'd0)
            rd2_fwd = '0;
        else if (WE3 && (rd_a2 == A3))
            rd2_fwd = WD3;
    end

endmodule

// File: tb/tb_mips_writeback_stage.sv
// Directed self-checking bench for mips_writeback_stage (32-bit and 4-bit counter instances).
module tb_mips_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_reg_write, mem_mem_to_reg;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_byte_off;
    logic [31:0] mem_alu_result, mem_read_data;
    logic [4:0]  mem_dest;
    logic        stall, flush;
    logic [4:0]  rd_a1, rd_a2;
    logic [31:0] rf_rd1, rf_rd2;

    logic        WE3, wb_valid;
    logic [4:0]  A3;
    logic [31:0] WD3, rd1_fwd, rd2_fwd, retired_count;

    logic        we3_s, wb_valid_s;
    logic [4:0]  a3_s;
    logic [31:0] wd3_s, rd1_s, rd2_s;
    logic [3:0]  count4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_writeback_stage #(.Width(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_load_type(mem_load_type),
        .mem_byte_off(mem_byte_off), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_dest(mem_dest), .stall(stall), .flush(flush),
        .rd_a1(rd_a1), .rd_a2(rd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .WE3(WE3), .A3(A3), .WD3(WD3), .rd1_fwd(rd1_fwd), .rd2_fwd(rd2_fwd),
        .wb_valid(wb_valid), .retired_count(retired_count)
    );

    mips_writeback_stage #(.Width(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_to_reg(mem_mem_to_reg), .mem_load_type(mem_load_type),
        .mem_byte_off(mem_byte_off), .mem_alu_result(mem_alu_result),
        .mem_read_data(mem_read_data), .mem_dest(mem_dest), .stall(stall), .flush(flush),
        .rd_a1(rd_a1), .rd_a2(rd_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .WE3(we3_s), .A3(a3_s), .WD3(wd3_s), .rd1_fwd(rd1_s), .rd2_fwd(rd2_s),
        .wb_valid(wb_valid_s), .retired_count(count4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one MEM-stage instruction and advance past the next rising edge.
    task automatic issue(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [1:0] off, input logic [31:0] alu, input logic [4:0] dst);
        mem_valid      = v;
        mem_reg_write  = rw;
        mem_mem_to_reg = m2r;
        mem_load_type  = lt;
        mem_byte_off   = off;
        mem_alu_result = alu;
        mem_dest       = dst;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        mem_valid = 0; mem_reg_write = 0; mem_mem_to_reg = 0;
        mem_load_type = 0; mem_byte_off = 0; mem_alu_result = 0;
        mem_read_data = 32'h80F17F02; mem_dest = 0;
        stall = 0; flush = 0;
        rd_a1 = 0; rd_a2 = 0; rf_rd1 = 0; rf_rd2 = 0;
        @(negedge clk);
        chk("reset_we3", WE3, 0);
        chk("reset_valid", wb_valid, 0);
        chk("reset_count", retired_count, 0);
        rst = 1'b1;

        // load extraction
        issue(1, 1, 1, 3'b001, 2'd3, 32'h0, 5'd5);
        chk("lb_off3", WD3, 32'hFFFFFF80);
        chk("lb_we3", WE3, 1);
        chk("lb_a3", A3, 5);
        issue(1, 1, 1, 3'b010, 2'd3, 32'h0, 5'd5);
        chk("lbu_off3", WD3, 32'h00000080);
        issue(1, 1, 1, 3'b001, 2'd1, 32'h0, 5'd5);
        chk("lb_off1", WD3, 32'h0000007F);
        issue(1, 1, 1, 3'b011, 2'd2, 32'h0, 5'd5);
        chk("lh_off2", WD3, 32'hFFFF80F1);
        chk("lh_we3", WE3, 1);
        issue(1, 1, 1, 3'b100, 2'd0, 32'h0, 5'd5);
        chk("lhu_off0", WD3, 32'h00007F02);
        issue(1, 1, 1, 3'b000, 2'd2, 32'h0, 5'd5);
        chk("lw", WD3, 32'h80F17F02);
        chk("lw_a3", A3, 5);
        chk("count_after_loads", retired_count, 5);

        // $0 suppression
        rd_a1 = 5'd0; rf_rd1 = 32'hDEAD;
        issue(1, 1, 0, 3'b000, 2'd0, 32'h1234, 5'd0);
        chk("r0_we3", WE3, 0);
        chk("r0_valid", wb_valid, 1);
        chk("r0_rd1_fwd", rd1_fwd, 0);

        // bypass
        rd_a1 = 5'd7; rd_a2 = 5'd8; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
        issue(1, 1, 0, 3'b000, 2'd0, 32'hCAFEBABE, 5'd7);
        chk("byp_rd1", rd1_fwd, 32'hCAFEBABE);
        chk("byp_rd2", rd2_fwd, 32'h22);
        issue(0, 0, 0, 3'b000, 2'd0, 32'h0, 5'd0);
        chk("byp_off_we3", WE3, 0);
        chk("byp_off_rd1", rd1_fwd, 32'h11);
        chk("count_before_rst", retired_count, 8);

        // asynchronous reset mid-write
        issue(1, 1, 0, 3'b000, 2'd0, 32'h55, 5'd3);
        chk("pre_rst_we3", WE3, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_we3", WE3, 0);
        chk("async_a3", A3, 0);
        chk("async_wd3", WD3, 0);
        chk("async_count", retired_count, 0);
        mem_valid = 0;
        @(negedge clk);
        rst = 1'b1;

        // stall for two cycles on the second instruction
        issue(1, 1, 0, 3'b000, 2'd0, 32'h101, 5'd1);
        issue(1, 1, 0, 3'b000, 2'd0, 32'h202, 5'd2);
        chk("stall_c0", WD3, 32'h202);
        stall = 1'b1;
        issue(1, 1, 0, 3'b000, 2'd0, 32'h303, 5'd3);
        chk("stall_c1", WD3, 32'h202);
        chk("stall_we3", WE3, 1);
        issue(1, 1, 0, 3'b000, 2'd0, 32'h303, 5'd3);
        chk("stall_c2", WD3, 32'h202);
        chk("stall_count", retired_count, 1);
        stall = 1'b0;
        issue(1, 1, 0, 3'b000, 2'd0, 32'h303, 5'd3);
        chk("stall_i3", WD3, 32'h303);
        issue(0, 0, 0, 3'b000, 2'd0, 32'h0, 5'd0);
        chk("stall_end_count", retired_count, 3);

        // flush together with stall
        do_reset();
        issue(1, 1, 0, 3'b000, 2'd0, 32'h101, 5'd1);
        issue(1, 1, 0, 3'b000, 2'd0, 32'h202, 5'd2);
        stall = 1'b1; flush = 1'b1;
        issue(1, 1, 0, 3'b000, 2'd0, 32'h303, 5'd3);
        chk("flush_valid", wb_valid, 0);
        chk("flush_we3", WE3, 0);
        chk("flush_count", retired_count, 1);
        stall = 1'b0; flush = 1'b0;
        issue(1, 1, 0, 3'b000, 2'd0, 32'h303, 5'd3);
        issue(0, 0, 0, 3'b000, 2'd0, 32'h0, 5'd0);
        chk("flush_end_count", retired_count, 2);

        // counter wrap on the 4-bit instance; mix of non-writing instructions
        do_reset();
        for (int i = 0; i < 17; i++)
            issue(1, i[0], 0, 3'b000, 2'd0, 32'(i), 5'd9);
        issue(0, 0, 0, 3'b000, 2'd0, 32'h0, 5'd0);
        chk("wrap_count4", 32'(count4), 1);
        chk("wrap_count32", retired_count, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_writeback_stage.md
Name: mips_writeback_stage

Overview:
- Writer-side companion to the MIPS register file.
- Holds the MEM/WB pipeline register and performs load-data extraction (lw/lb/lbu/lh/lhu).
- Drives the register file write port (WE3/A3/WD3) and suppresses writes to $0.
- Provides write-through bypass of the register file read data for same-cycle read-after-write, and keeps a retired-instruction counter.

Parameters:
- Width, 32, datapath width; only 32 is supported because the load extraction assumes 4-byte words.
- CNT_W, 32, width of retired_count.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- mem_valid  input  1  MEM stage holds a valid instruction
- mem_reg_write  input  1  instruction writes a register
- mem_mem_to_reg  input  1  1: result is load data; 0: result is ALU result
- mem_load_type  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others behave as lw
- mem_byte_off  input  2  effective address [1:0]
- mem_alu_result  input  Width  ALU result
- mem_read_data  input  Width  raw data-memory word
- mem_dest  input  5  destination register number
- stall  input  1  hold the WB register
- flush  input  1  insert a bubble into WB
- rd_a1  input  5  register file read address 1 (same value as A1)
- rd_a2  input  5  register file read address 2 (same value as A2)
- rf_rd1  input  Width  register file RD1
- rf_rd2  input  Width  register file RD2
- WE3  output  1  register file write enable
- A3  output  5  register file write address
- WD3  output  Width  register file write data
- rd1_fwd  output  Width  bypassed read data 1
- rd2_fwd  output  Width  bypassed read data 2
- wb_valid  output  1  WB register holds a valid instruction
- retired_count  output  CNT_W  count of instructions leaving WB

Behaviour:
- Reset (rst=0, asynchronous): wb_valid, WE3, A3, WD3 and retired_count all 0. The internal WB register (reg_write, dest, data) is cleared. An in-flight write is dropped; no partial write occurs.
- WB register update on posedge clk:
  - flush=1: wb_valid<=0. Flush has priority over stall. The data fields may keep their old values.
  - else stall=1: all WB fields hold.
  - else: wb_valid<=mem_valid, wb_reg_write<=mem_reg_write, wb_dest<=mem_dest, wb_data<=result.
- Latency: one cycle from MEM inputs to WE3/A3/WD3.
- result = mem_mem_to_reg ? load_ext : mem_alu_result.
- load_ext (little-endian, byte k = bits 8k+7:8k):
  - lw: the whole word; offset ignored.
  - lb/lbu: byte mem_byte_off, sign-/zero-extended.
  - lh/lhu: mem_byte_off[1]=0 selects [15:0], =1 selects [31:16], sign-/zero-extended; mem_byte_off[0] ignored.
- Write port:
  - A3=wb_dest, WD3=wb_data.
  - WE3 = wb_valid & wb_reg_write & (wb_dest!=0), combinational from the WB register.
  - While stalled, WE3 stays asserted and rewrites the same value. This is idempotent and allowed.
- Bypass (combinational):
  - rdN_fwd = 0 if rd_aN==0.
  - else WD3 if WE3 & (rd_aN==A3).
  - else rf_rdN.
- retired_count: increments by 1 on a posedge where wb_valid=1 and stall=0 and flush=0. It wraps modulo 2^CNT_W. Instructions that do not write (stores, branches) also count.
- Simultaneous flush+stall: the bubble is inserted and retired_count does not increment.
- mem_valid=0 with reg_write=1: no write occurs (wb_valid=0).

Test Plan:
1. Reset: rst=0 mid-operation with WE3=1 -> WE3=0, A3=0, WD3=0, retired_count=0 immediately, without waiting for a clock edge.
2. Load extraction, read_data=0x80F17F02, mem_to_reg=1, dest=5:
   - lb off=3 -> WD3=0xFFFFFF80.
   - lbu off=3 -> 0x00000080.
   - lb off=1 -> 0x0000007F.
   - lh off=2 -> 0xFFFF80F1.
   - lhu off=0 -> 0x00007F02.
   - lw -> 0x80F17F02.
   - In every case WE3=1 and A3=5 one cycle later.
3. $0 suppression: reg_write=1, dest=0, alu=0x1234 -> WE3=0. With rd_a1=0 and rf_rd1=0xDEAD, rd1_fwd=0.
4. Bypass: WB writes 0xCAFEBABE to r7 while rd_a1=7, rd_a2=8, rf_rd1=0x11, rf_rd2=0x22 -> rd1_fwd=0xCAFEBABE, rd2_fwd=0x22. On the next cycle with WE3=0 -> rd1_fwd=rf_rd1.
5. Stall/flush: 3 valid instructions with stall=1 for 2 cycles on the 2nd -> WD3 holds for 3 cycles and retired_count ends at 3. Repeat with flush+stall asserted together -> wb_valid=0 next cycle and retired_count ends at 2.
6. Counter wrap: CNT_W=4, 17 valid instructions -> retired_count=1.
